// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants: operation codes, opcode prefixes,
// immediate limits and error codes used by the encoder and control decoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MOVZ = 4'd6,
        OP_B    = 4'd7,
        OP_CBZ  = 4'd8,
        OP_LDUR = 4'd9,
        OP_STUR = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_ALIGN   = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    localparam int signed ADDI_IMM_MAX = 4095;
    localparam int signed MOVZ_IMM_MAX = 65535;
    localparam int unsigned B_IMM_W    = 26;
    localparam int unsigned CBZ_IMM_W  = 19;
    localparam int unsigned DT_IMM_W   = 9;

    // True when v is representable as a w-bit two's complement value.
    function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (w - 1);
        return (v >= -lim) && (v < lim);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Tuple-in / word-out handshake bundle between the program builder and
// the instruction-memory loader.
interface instr_encoder_if #(
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [1:0]        in_hw;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_hw, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_addr
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_hw, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_addr
    );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational field packer: one operation tuple to a 32-bit LEGv8 word,
// with immediate range and illegal-op flags.
module instr_field_pack
    import legv8_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [1:0]  i_hw,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_range_err,
    output logic        o_illegal
);
    logic signed [31:0] w_imm;
    assign w_imm = signed'(i_imm);

    always_comb begin
        o_word      = '0;
        o_range_err = 1'b0;
        o_illegal   = 1'b0;
        case (i_op)
            OP_AND:  o_word = {OPC_AND, i_rm, 6'b000000, i_rn, i_rd};
            OP_ORR:  o_word = {OPC_ORR, i_rm, 6'b000000, i_rn, i_rd};
            OP_ADD:  o_word = {OPC_ADD, i_rm, 6'b000000, i_rn, i_rd};
            OP_SUB:  o_word = {OPC_SUB, i_rm, 6'b000000, i_rn, i_rd};
            OP_ADDI, OP_SUBI: begin
                o_word      = {(i_op == OP_ADDI) ? OPC_ADDI : OPC_SUBI, i_imm[11:0], i_rn, i_rd};
                o_range_err = (w_imm < 0) || (w_imm > ADDI_IMM_MAX);
            end
            OP_MOVZ: begin
                o_word      = {OPC_MOVZ, i_hw, i_imm[15:0], i_rd};
                o_range_err = (w_imm < 0) || (w_imm > MOVZ_IMM_MAX);
            end
            // Branch offsets are word offsets and go in unscaled.
            OP_B: begin
                o_word      = {OPC_B, i_imm[25:0]};
                o_range_err = !fits_signed(w_imm, B_IMM_W);
            end
            OP_CBZ: begin
                o_word      = {OPC_CBZ, i_imm[18:0], i_rd};
                o_range_err = !fits_signed(w_imm, CBZ_IMM_W);
            end
            OP_LDUR, OP_STUR: begin
                o_word      = {(i_op == OP_LDUR) ? OPC_LDUR : OPC_STUR, i_imm[8:0], 2'b00, i_rn, i_rd};
                o_range_err = !fits_signed(w_imm, DT_IMM_W);
            end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Streaming LEGv8 instruction encoder: session FSM, one-word output
// register, byte-address counter and delivered-word counter.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MAX_INSTR = 256
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic [8:0]        count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam logic [9:0] MAX_CNT = 10'(MAX_INSTR);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [8:0]        r_count, w_count_nxt;
    logic              r_err, w_err_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [31:0]       r_out_word, w_out_word_nxt;

    logic [31:0]       w_pack_word;
    logic              w_range_err, w_illegal;
    logic              w_deliver, w_room, w_in_ready, w_accept, w_misaligned;

    instr_field_pack u_pack (
        .i_op        (bus.in_op),
        .i_rd        (bus.in_rd),
        .i_rn        (bus.in_rn),
        .i_rm        (bus.in_rm),
        .i_hw        (bus.in_hw),
        .i_imm       (bus.in_imm),
        .o_word      (w_pack_word),
        .o_range_err (w_range_err),
        .o_illegal   (w_illegal)
    );

    // Room counts the word still in the output register, so the session never overshoots.
    assign w_deliver    = r_out_valid && bus.out_ready;
    assign w_room       = ({1'b0, r_count} + {9'b0, r_out_valid}) < MAX_CNT;
    assign w_in_ready   = (r_state == S_RUN) && !r_err && w_room &&
                          (!r_out_valid || bus.out_ready) && !start;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_misaligned = (base_addr[1:0] != 2'b00);

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_word  <= w_out_word_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_count_nxt     = r_count;
        w_err_nxt       = r_err;
        w_err_code_nxt  = r_err_code;
        w_out_valid_nxt = r_out_valid;
        w_out_word_nxt  = r_out_word;
        if (start) begin
            w_state_nxt     = w_misaligned ? S_HALT : S_RUN;
            w_addr_nxt      = base_addr;
            w_count_nxt     = '0;
            w_out_valid_nxt = 1'b0;
            w_err_nxt       = w_misaligned;
            w_err_code_nxt  = w_misaligned ? ERR_ALIGN : ERR_NONE;
        end else begin
            if (w_deliver) begin
                w_addr_nxt      = r_addr + ADDR_W'(4);
                w_count_nxt     = r_count + 9'd1;
                w_out_valid_nxt = 1'b0;
            end
            if (w_accept) begin
                if (w_illegal || w_range_err) begin
                    w_state_nxt    = S_HALT;
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_illegal ? ERR_ILLEGAL : ERR_RANGE;
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_out_word_nxt  = w_pack_word;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_word  = r_out_word;
    assign bus.out_addr  = r_addr;
    assign count         = r_count;
    assign full          = ({1'b0, r_count} == MAX_CNT);
    assign err           = r_err;
    assign err_code      = r_err_code;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming LEGv8 instruction encoder: turns (operation, register fields, immediate) tuples into 32-bit instruction words and hands them to the instruction-memory loader with a byte address.
- Produces exactly the encodings the single-cycle control decoder recognises.
- Used by the self-loading test harness to build programs in instruction memory before the processor is released from reset.

Parameters:
- ADDR_W, 64, width of the byte address driven to instruction memory.
- MAX_INSTR, 256, number of words accepted per programming session before the block reports full.

Ports:
- CLK  in  1  clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a session at base_addr, clears err and count.
- base_addr  in  ADDR_W  first byte address of the session; must be word-aligned.
- in_valid  in  1  an operation tuple is presented.
- in_ready  out  1  the block accepts the tuple this cycle.
- in_op  in  4  operation code: AND=0, ORR=1, ADD=2, SUB=3, ADDI=4, SUBI=5, MOVZ=6, B=7, CBZ=8, LDUR=9, STUR=10.
- in_rd  in  5  Rd, or Rt for CBZ/LDUR/STUR.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm.
- in_hw  in  2  MOVZ shift selector.
- in_imm  in  32  immediate, two's complement.
- out_valid  out  1  word and address are valid.
- out_ready  in  1  the instruction memory takes the word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_word.
- count  out  9  words delivered this session.
- full  out  1  count == MAX_INSTR.
- err  out  1  sticky error flag.
- err_code  out  2  1 = illegal op, 2 = immediate out of range, 3 = misaligned base_addr.

Behaviour:
- Reset: all outputs 0; state IDLE.
- State IDLE: in_ready = 0. start goes to RUN, loads the address counter with base_addr, clears count and err.
- If base_addr[1:0] != 0 at start: go to HALT with err = 1, err_code = 3.
- State RUN: in_ready = !err && !full && (!out_valid || out_ready).
- Accept on in_valid && in_ready. The word is registered, so out_valid rises the next cycle (latency 1). out_word and out_addr stay stable while out_valid && !out_ready.
- Back-to-back transfers run at full throughput: a new tuple is accepted in the same cycle the previous word transfers.
- Delivery on out_valid && out_ready: out_addr advances by 4 with wrap modulo 2^ADDR_W, and count increments.
- Delivery while full, or a delivery that makes count reach MAX_INSTR: in_ready drops, and the block stays in RUN until the next start.
- Encodings (bits 31..0):
  - AND: 10001010000 | Rm | 000000 | Rn | Rd.
  - ORR: 10101010000 | Rm | 000000 | Rn | Rd.
  - ADD: 10001011000 | Rm | 000000 | Rn | Rd.
  - SUB: 11001011000 | Rm | 000000 | Rn | Rd.
  - ADDI: 1001000100 | imm[11:0] | Rn | Rd.
  - SUBI: 1101000100 | imm[11:0] | Rn | Rd.
  - MOVZ: 110100101 | hw | imm[15:0] | Rd.
  - B: 000101 | imm[25:0].
  - CBZ: 10110100 | imm[18:0] | Rt.
  - LDUR: 11111000010 | imm[8:0] | 00 | Rn | Rt.
  - STUR: 11111000000 | imm[8:0] | 00 | Rn | Rt.
- Immediate range checks, evaluated at acceptance:
  - ADDI/SUBI: 0..4095.
  - MOVZ: 0..65535.
  - B: signed 26-bit.
  - CBZ: signed 19-bit.
  - LDUR/STUR: signed 9-bit.
  - The branch immediate is a word offset, passed through unscaled.
- Violation, or in_op > 10: the tuple is consumed but no word is produced. err = 1 with its err_code; state HALT.
- HALT: in_ready = 0. A word already in the output register still completes. Only start leaves HALT.
- start while in RUN: aborts the session. Any pending out_valid is dropped the next cycle, and the counter is reloaded.
- start has priority over a simultaneous accept, and that tuple is not consumed.
- Reset mid-transfer: out_valid drops immediately (asynchronous reset).

Decomposition:
- Shared package legv8_pkg holds:
  - the op enum;
  - the opcode field constants (11/10/9/8/6-bit prefixes above);
  - the immediate limits;
  - the err_code values.
- The control decoder's opcode patterns are kept consistent with these constants.
- One natural sub-module, instr_field_pack: combinational op + fields → {word, range_err, illegal}. The parent holds the FSM, the output register and the counters.

Test Plan:
- start with base_addr 0x100, then ADD rd=3 rn=1 rm=2 with out_ready = 1 → one cycle later out_word 0x8B020023, out_addr 0x100, count 1.
- Back-to-back ADDI rd=2 rn=31 imm=5, then B imm=-2 → ADDI word 0x910017E2 at 0x100; B word 0x17FFFFFE at 0x104 the next cycle.
- out_ready held 0 for 3 cycles after LDUR rt=5 rn=2 imm=8 → out_word 0xF8408045 stable, in_ready = 0, count unchanged until release.
- ADDI imm=4096 → err = 1, err_code 2, no out_valid, in_ready = 0; a following start clears err.
- MAX_INSTR = 4 build, 5 tuples → 4 words at 0x0..0xC, full = 1, fifth tuple not accepted.
- start with base_addr 0x102 → err_code 3; resetl pulsed low while out_valid → all outputs 0 asynchronously.
